vote_collector: RTL and testbench
=================================

Name: vote_collector

Overview:
Ballot collection stage directly upstream of the 4-input voter decision block (voter_if).
- Opens a voting round and accepts at most one vote per voter (first vote wins).
- Seals the round when all 4 voters have voted or a timeout expires.
- Presents the sealed 4-bit ballot through a valid/ready handshake. The ballot bus connects to the voter's 4-bit input I.

Parameters:
- TIMEOUT, 16, max COLLECT cycles before forced seal; legal range 2..255.
- TMR_W, $clog2(TIMEOUT+1), timer width; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- round_start  in  1  one-cycle pulse; opens a round (honoured in IDLE only).
- vote_valid  in  4  per-voter strobe; bit i = voter i casting this cycle.
- vote_yes  in  4  per-voter value; sampled with vote_valid[i]; 1 = yes, 0 = no.
- ballot  out  4  sealed votes; unvoted bits read 0 (no); feeds voter_if I.
- voted_mask  out  4  bit i = voter i has voted in the current/last round.
- ballot_valid  out  1  sealed ballot available.
- ballot_ready  in  1  downstream accepts ballot.
- timed_out  out  1  last round sealed by timeout rather than full participation.
- busy  out  1  high in COLLECT or SEALED.

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; ballot, voted_mask, ballot_valid, timed_out, busy, timer all 0.
  - Reset mid-round discards all collected votes.
- States are IDLE, COLLECT and SEALED; all outputs are registered.
- IDLE:
  - round_start=1 -> COLLECT next cycle.
  - On that edge, ballot, voted_mask, timed_out and timer are cleared to 0.
  - ballot, voted_mask and timed_out otherwise hold the previous round's result.
- COLLECT:
  - For each i with vote_valid[i]=1 and voted_mask[i]=0: ballot[i] <= vote_yes[i], voted_mask[i] <= 1.
  - Repeat votes from an already-voted voter are ignored.
  - Multiple voters may vote in the same cycle.
  - Timer increments by 1 each COLLECT cycle.
- Seal conditions (evaluated on the updated mask):
  - Mask == 4'hF -> SEALED, timed_out=0.
  - Else timer == TIMEOUT-1 -> SEALED, timed_out=1.
  - Votes arriving on the timeout cycle are counted.
  - If the final missing vote arrives on the timeout cycle, timed_out=0.
- Latency:
  - Cycle carrying the last vote = N; ballot_valid=1 at N+1.
  - With no votes at all, ballot_valid rises exactly TIMEOUT cycles after entering COLLECT.
- SEALED:
  - ballot_valid=1; ballot and voted_mask stable.
  - vote_valid is ignored.
  - ballot_valid and ballot_ready both 1 on an edge -> IDLE; ballot_valid=0 next cycle.
  - ballot_ready may be held high continuously; the minimum SEALED residency is 1 cycle.
- round_start is ignored in COLLECT and SEALED; a pulse arriving on the handshake cycle is dropped.
- busy = (state != IDLE).

Optional Feature:
- Macro: VOTE_COLLECTOR_SYNC_EN.
- Defined:
  - vote_valid and vote_yes each pass through a 2-flop synchronizer (reset to 0) before the COLLECT logic.
  - Vote-to-ballot_valid latency becomes N+3.
  - A strobe arriving in the last 2 COLLECT cycles may miss the round.
- Undefined: inputs are used directly, latency N+1, no extra flops.

Decomposition:
- Package vote_pkg holds:
  - NUM_VOTERS = 4.
  - Enum state_t {IDLE, COLLECT, SEALED}.
  - Typedef ballot_t = logic [NUM_VOTERS-1:0].
- One natural sub-module, vote_timeout_timer:
  - Inputs: clr, en.
  - Outputs: expired and count.
  - Parameterised by TIMEOUT.
- The synchronizer lives inline under the macro.

Test Plan:
- Full round: round_start; vote_valid=4'b0101, vote_yes=4'b0001 at cycle 2; vote_valid=4'b1010, vote_yes=4'b1000 at cycle 4 -> ballot_valid at cycle 5, ballot=4'b1001, voted_mask=4'hF, timed_out=0.
- Timeout: round_start, single vote voter0 yes, TIMEOUT=16 -> ballot_valid 16 cycles after COLLECT entry, ballot=4'b0001, voted_mask=4'b0001, timed_out=1.
- Re-vote: voter2 votes yes, then later votes no -> ballot[2]=1 retained.
- Last vote on the timeout cycle -> voted_mask=4'hF, timed_out=0.
- Back-pressure: hold ballot_ready=0 for 10 cycles in SEALED while toggling vote_valid and pulsing round_start:
  - ballot and ballot_valid stay stable; no new round starts.
  - ready=1 -> IDLE next cycle.
- Reset mid-COLLECT with 3 votes in: rst_n low 1 cycle -> all outputs 0 immediately; the next round starts clean.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and helpers for the ballot collection stage feeding voter_if.
package vote_pkg;

    localparam int NUM_VOTERS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEALED  = 2'd2
    } state_t;

    typedef logic [NUM_VOTERS-1:0] ballot_t;

    localparam ballot_t ALL_VOTED = {NUM_VOTERS{1'b1}};

    // Strobes from voters that have not voted yet this round (first vote wins).
    function automatic ballot_t first_votes(input ballot_t mask, input ballot_t strobe);
        return strobe & ~mask;
    endfunction

endpackage

// File: rtl/vote_timeout_timer.sv
// COLLECT-phase cycle counter; expired flags the last permitted COLLECT cycle.
module vote_timeout_timer #(
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic             expired,
    output logic [TMR_W-1:0] count
);

    logic [TMR_W-1:0] count_r;

    // Cycle counter: clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {TMR_W{1'b0}};
        end else if (clr) begin
            count_r <= {TMR_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign expired = (count_r == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/vote_collector.sv
// Ballot collector: one vote per voter per round, sealed on full turnout or timeout.
// Optional input synchronizer enabled by defining VOTE_COLLECTOR_SYNC_EN.
module vote_collector
    import vote_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       round_start,
    input  logic [3:0] vote_valid,
    input  logic [3:0] vote_yes,
    output logic [3:0] ballot,
    output logic [3:0] voted_mask,
    output logic       ballot_valid,
    input  logic       ballot_ready,
    output logic       timed_out,
    output logic       busy
);

    state_t           state_r, state_next_s;
    ballot_t          ballot_r, mask_r;
    logic             valid_r, timed_out_r, busy_r;
    ballot_t          vv_s, vy_s, fresh_s, mask_next_s, ballot_next_s;
    logic             tmr_clr_s, tmr_en_s, tmr_expired_s, timeout_hit_s;
    logic             seal_s, seal_timeout_s;
    logic [TMR_W-1:0] tmr_count_s;

`ifdef VOTE_COLLECTOR_SYNC_EN
    ballot_t vv_meta_r, vv_sync_r, vy_meta_r, vy_sync_r;

    // Two-flop synchronizer on the voter strobes and values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vv_meta_r <= 4'b0000;
            vv_sync_r <= 4'b0000;
            vy_meta_r <= 4'b0000;
            vy_sync_r <= 4'b0000;
        end else begin
            vv_meta_r <= vote_valid;
            vv_sync_r <= vv_meta_r;
            vy_meta_r <= vote_yes;
            vy_sync_r <= vy_meta_r;
        end
    end

    assign vv_s = vv_sync_r;
    assign vy_s = vy_sync_r;
`else
    assign vv_s = vote_valid;
    assign vy_s = vote_yes;
`endif

    assign tmr_clr_s = (state_r == IDLE) && round_start;
    assign tmr_en_s  = (state_r == COLLECT);

    vote_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (tmr_expired_s),
        .count   (tmr_count_s)
    );

    // Vote merge and next-state decision; a corrupted count past the limit also forces a seal.
    always_comb begin
        fresh_s        = first_votes(mask_r, vv_s);
        mask_next_s    = mask_r | fresh_s;
        ballot_next_s  = ballot_r | (fresh_s & vy_s);
        timeout_hit_s  = tmr_expired_s || (tmr_count_s > TMR_W'(TIMEOUT - 1));
        seal_s         = 1'b0;
        seal_timeout_s = 1'b0;
        state_next_s   = state_r;
        case (state_r)
            IDLE: begin
                if (round_start) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (mask_next_s == ALL_VOTED) begin
                    state_next_s = SEALED;
                    seal_s       = 1'b1;
                end else if (timeout_hit_s) begin
                    state_next_s   = SEALED;
                    seal_s         = 1'b1;
                    seal_timeout_s = 1'b1;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            SEALED: begin
                if (ballot_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEALED;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs; the ballot holds the last result until the next round opens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ballot_r    <= 4'b0000;
            mask_r      <= 4'b0000;
            valid_r     <= 1'b0;
            timed_out_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r <= (state_next_s == SEALED);
            busy_r  <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (round_start) begin
                        ballot_r    <= 4'b0000;
                        mask_r      <= 4'b0000;
                        timed_out_r <= 1'b0;
                    end
                end
                COLLECT: begin
                    ballot_r <= ballot_next_s;
                    mask_r   <= mask_next_s;
                    if (seal_s) begin
                        timed_out_r <= seal_timeout_s;
                    end
                end
                default: begin
                    ballot_r <= ballot_r;
                    mask_r   <= mask_r;
                end
            endcase
        end
    end

    assign ballot       = ballot_r;
    assign voted_mask   = mask_r;
    assign ballot_valid = valid_r;
    assign timed_out    = timed_out_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector with a per-voter reference model checked every cycle.
module tb_vote_collector;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       round_start = 1'b0;
    logic       ballot_ready = 1'b0;
    logic [3:0] vote_valid = 4'b0000;
    logic [3:0] vote_yes = 4'b0000;
    logic [3:0] ballot, voted_mask;
    logic       ballot_valid, timed_out, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vote_collector #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .round_start  (round_start),
        .vote_valid   (vote_valid),
        .vote_yes     (vote_yes),
        .ballot       (ballot),
        .voted_mask   (voted_mask),
        .ballot_valid (ballot_valid),
        .ballot_ready (ballot_ready),
        .timed_out    (timed_out),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: round open/sealed flags, age of the round, per-voter record.
    bit m_open, m_sealed, m_to;
    int m_age, m_turnout;
    bit m_cast[4];
    bit m_yes[4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_sealed = 0; m_to = 0; m_age = 0;
            for (int i = 0; i < 4; i++) begin m_cast[i] = 0; m_yes[i] = 0; end
        end else if (m_sealed) begin
            if (ballot_ready) m_sealed = 0;
        end else if (m_open) begin
            m_turnout = 0;
            for (int i = 0; i < 4; i++) begin
                if (vote_valid[i] && !m_cast[i]) begin
                    m_cast[i] = 1;
                    m_yes[i]  = vote_yes[i];
                end
                if (m_cast[i]) m_turnout++;
            end
            if (m_turnout == 4) begin
                m_open = 0; m_sealed = 1; m_to = 0;
            end else if (m_age == TIMEOUT - 1) begin
                m_open = 0; m_sealed = 1; m_to = 1;
            end
            m_age++;
        end else if (round_start) begin
            m_open = 1; m_age = 0; m_to = 0;
            for (int i = 0; i < 4; i++) begin m_cast[i] = 0; m_yes[i] = 0; end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [3:0] eb, em;
        for (int i = 0; i < 4; i++) begin
            eb[i] = m_cast[i] & m_yes[i];
            em[i] = m_cast[i];
        end
        check("model", {21'b0, ballot, voted_mask, ballot_valid, timed_out, busy},
              {21'b0, eb, em, m_sealed, m_to, m_open | m_sealed});
    end

    task automatic cyc(input logic rs, input logic [3:0] vv, input logic [3:0] vy, input logic rdy);
        round_start  = rs;
        vote_valid   = vv;
        vote_yes     = vy;
        ballot_ready = rdy;
        @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return {21'b0, ballot, voted_mask, ballot_valid, timed_out, busy};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 32'h0);
        rst_n = 1'b1;
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Full participation in two bursts.
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0101, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("full_not_yet_valid", {31'b0, ballot_valid}, 32'h0);
        cyc(1'b0, 4'b1010, 4'b1000, 1'b0);
        check("full_valid", {31'b0, ballot_valid}, 32'h1);
        check("full_ballot", {28'b0, ballot}, 32'h9);
        check("full_mask", {28'b0, voted_mask}, 32'hF);
        check("full_timed_out", {31'b0, timed_out}, 32'h0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1);
        check("full_after_ack", {30'b0, ballot_valid, busy}, 32'h0);
        check("full_ballot_held", {28'b0, ballot}, 32'h9);

        // Timeout with a single vote.
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0001, 1'b0);
        repeat (14) cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("to_not_yet_valid", {31'b0, ballot_valid}, 32'h0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("to_valid", {31'b0, ballot_valid}, 32'h1);
        check("to_ballot", {28'b0, ballot}, 32'h1);
        check("to_mask", {28'b0, voted_mask}, 32'h1);
        check("to_timed_out", {31'b0, timed_out}, 32'h1);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Re-vote ignored; final vote lands on the timeout cycle.
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0011, 1'b0);
        repeat (12) cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("last_not_yet_valid", {31'b0, ballot_valid}, 32'h0);
        cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
        check("last_ballot", {28'b0, ballot}, 32'h7);
        check("last_mask", {28'b0, voted_mask}, 32'hF);
        check("last_timed_out", {31'b0, timed_out}, 32'h0);

        // Back-pressure: inputs wiggle, sealed result must not move.
        for (int i = 0; i < 10; i++) begin
            cyc(i % 2 == 0, 4'(i * 7 + 1), ~4'(i * 7 + 1), 1'b0);
            check("bp_stable", {27'b0, ballot, ballot_valid}, 32'h0F);
        end
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1);
        check("bp_released", {30'b0, ballot_valid, busy}, 32'h0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("handshake_start_dropped", {31'b0, busy}, 32'h0);

        // Reset in the middle of collection.
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0111, 4'b0101, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs", outs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1000, 4'b1000, 1'b0);
        repeat (15) cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("clean_round", outs(), {21'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1});
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
